// File: rtl/sram_ctrl_multibeat.sv
// Multi-beat SRAM controller: splits one DATA_W access into DATA_W/SRAM_DW narrow
// SRAM beats, each stretched by WAIT_CYC hold cycles, stalling the pipeline via ready.
module sram_ctrl_multibeat #(
  parameter int DATA_W   = 32,
  parameter int SRAM_DW  = 16,
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w_en,
  input  logic              mem_r_en,
  input  logic [31:0]       addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  // state | meaning
  // IDLE  | waiting for a load/store; ready follows the request lines
  // BUSY  | issuing beats b=0..BEATS-1, each held for WAIT_CYC+1 cycles
  // DONE  | access complete, ready=1 for one cycle; requests ignored
  localparam int BEATS = DATA_W / SRAM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [BW-1:0]     b;
  logic [3:0]        w;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_wr;
  logic              last_w;
  logic              last_b;
  logic              drive;

  assign last_w = (w == 4'(WAIT_CYC));
  assign last_b = (b == BW'(BEATS - 1));

  generate
    if (ADDR_W < 32) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_in[31:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      b       <= '0;
      w       <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          b <= '0;
          w <= '0;
          if (mem_w_en) begin
            addr_q  <= addr_in[ADDR_W-1:0];
            wdata_q <= wdata;
            op_wr   <= 1'b1;
            state   <= S_BUSY;
          end else if (mem_r_en) begin
            addr_q <= addr_in[ADDR_W-1:0];
            op_wr  <= 1'b0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Read data is sampled on the edge that closes the beat.
          if (!op_wr && last_w)
            rdata[b*SRAM_DW +: SRAM_DW] <= sram_dq;
          if (last_w) begin
            w <= '0;
            if (last_b) begin
              b     <= '0;
              state <= S_DONE;
            end else begin
              b <= b + 1'b1;
            end
          end else begin
            w <= w + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready     = ~(mem_w_en | mem_r_en);
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    drive     = 1'b0;
    case (state)
      S_BUSY: begin
        ready     = 1'b0;
        sram_addr = addr_q + ADDR_W'(b);
        if (op_wr) begin
          sram_we_n = 1'b0;
          drive     = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      S_DONE:  ready = 1'b1;
      default: ;
    endcase
  end

  assign sram_dq = drive ? wdata_q[b*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// Scoreboard bench: two controller instances (32/16 no wait, 64/16 with 2 wait states)
// with simple SRAM models; expected bus beats and completions are queued and checked by monitors.
module tb_sram_ctrl_multibeat;

  localparam logic [15:0] KEEP = 16'hA5A5;
  localparam logic [1:0]  EV_W = 2'd0;
  localparam logic [1:0]  EV_R = 2'd1;
  localparam logic [1:0]  EV_D = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [17:0] addr;
    logic [63:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ev_t q0[$];
  ev_t q1[$];

  // instance 0: defaults
  logic        w_en0 = 0, r_en0 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0;
  logic [31:0] rdata0;
  logic        ready0, we_n0, oe_n0;
  logic [17:0] saddr0;
  wire  [15:0] dq0;
  logic [15:0] mem0 [0:1023];

  // instance 1: 64-bit word, 2 wait states
  logic        w_en1 = 0, r_en1 = 0;
  logic [31:0] addr1 = 0;
  logic [63:0] wdata1 = 0;
  logic [63:0] rdata1;
  logic        ready1, we_n1, oe_n1;
  logic [17:0] saddr1;
  wire  [15:0] dq1;
  logic [15:0] mem1 [0:1023];

  sram_ctrl_multibeat d0 (
    .clk(clk), .rst(rst), .mem_w_en(w_en0), .mem_r_en(r_en0), .addr_in(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .sram_dq(dq0),
    .sram_addr(saddr0), .sram_we_n(we_n0), .sram_oe_n(oe_n0));

  sram_ctrl_multibeat #(.DATA_W(64), .SRAM_DW(16), .ADDR_W(18), .WAIT_CYC(2)) d1 (
    .clk(clk), .rst(rst), .mem_w_en(w_en1), .mem_r_en(r_en1), .addr_in(addr1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .sram_dq(dq1),
    .sram_addr(saddr1), .sram_we_n(we_n1), .sram_oe_n(oe_n1));

  // SRAM models; a keeper pattern sits on the bus whenever nobody should drive it
  assign dq0 = !oe_n0 ? mem0[saddr0[9:0]] : (we_n0 ? KEEP : 16'bz);
  assign dq1 = !oe_n1 ? mem1[saddr1[9:0]] : (we_n1 ? KEEP : 16'bz);

  always @(posedge clk) if (!we_n0) mem0[saddr0[9:0]] <= dq0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [1:0] k, input logic [17:0] a, input logic [63:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Monitor, instance 0
  logic prev_act0 = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    logic act;
    if (rst) prev_act0 <= 1'b0;
    else begin
      act = !we_n0 || !oe_n0;
      if (act) begin
        if (q0.size() == 0) chk("d0_unexpected_beat", {46'b0, saddr0}, 64'hFFFF);
        else begin
          e = q0.pop_front();
          chk("d0_beat_kind", {62'b0, !we_n0 ? EV_W : EV_R}, {62'b0, e.kind});
          chk("d0_beat_addr", {46'b0, saddr0}, {46'b0, e.addr});
          if (!we_n0) chk("d0_beat_dq", {48'b0, dq0}, e.data);
        end
      end else begin
        chk("d0_bus_free", {48'b0, dq0}, {48'b0, KEEP});
        if (prev_act0) begin
          chk("d0_done_ready", {63'b0, ready0}, 64'd1);
          if (q0.size() == 0) chk("d0_unexpected_done", {32'b0, rdata0}, 64'hFFFF);
          else begin
            e = q0.pop_front();
            chk("d0_done_kind", {62'b0, EV_D}, {62'b0, e.kind});
            chk("d0_rdata", {32'b0, rdata0}, e.data);
          end
        end
      end
      prev_act0 <= act;
    end
  end

  // Monitor, instance 1
  logic prev_act1 = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    logic act;
    if (rst) prev_act1 <= 1'b0;
    else begin
      act = !we_n1 || !oe_n1;
      if (act) begin
        if (q1.size() == 0) chk("d1_unexpected_beat", {46'b0, saddr1}, 64'hFFFF);
        else begin
          e = q1.pop_front();
          chk("d1_beat_kind", {62'b0, !we_n1 ? EV_W : EV_R}, {62'b0, e.kind});
          chk("d1_beat_addr", {46'b0, saddr1}, {46'b0, e.addr});
        end
      end else begin
        chk("d1_bus_free", {48'b0, dq1}, {48'b0, KEEP});
        if (prev_act1) begin
          chk("d1_done_ready", {63'b0, ready1}, 64'd1);
          if (q1.size() == 0) chk("d1_unexpected_done", rdata1, 64'hFFFF);
          else begin
            e = q1.pop_front();
            chk("d1_done_kind", {62'b0, EV_D}, {62'b0, e.kind});
            chk("d1_rdata", rdata1, e.data);
          end
        end
      end
      prev_act1 <= act;
    end
  end

  // Issue a request, hold it until ready is seen (DONE), drop it after that edge.
  task automatic do_req(input int sel, input logic we, input logic re,
                        input logic [31:0] a, input logic [63:0] wd);
    logic seen;
    if (sel == 0) begin w_en0 = we; r_en0 = re; addr0 = a; wdata0 = wd[31:0]; end
    else          begin w_en1 = we; r_en1 = re; addr1 = a; wdata1 = wd; end
    @(negedge clk);
    chk("req_ready_low", {63'b0, sel == 0 ? ready0 : ready1}, 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = (sel == 0) ? ready0 : ready1;
    end
    if (!seen) chk("req_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    w_en0 = 0; r_en0 = 0; w_en1 = 0; r_en1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    mem1[10'h10] = 16'h1111; mem1[10'h11] = 16'h2222;
    mem1[10'h12] = 16'h3333; mem1[10'h13] = 16'h4444;

    #12;
    chk("rst_ready", {63'b0, ready0}, 64'd1);
    chk("rst_we_n", {63'b0, we_n0}, 64'd1);
    chk("rst_oe_n", {63'b0, oe_n0}, 64'd1);
    chk("rst_addr", {46'b0, saddr0}, 64'd0);
    chk("rst_rdata", {32'b0, rdata0}, 64'd0);
    chk("rst_dq", {48'b0, dq0}, {48'b0, KEEP});
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // store 0xDEADBEEF; upper address bits must be ignored
    push(0, EV_W, 18'h00100, 64'hBEEF);
    push(0, EV_W, 18'h00101, 64'hDEAD);
    push(0, EV_D, 18'h0, 64'h0);
    do_req(0, 1, 0, 32'hFFFC_0100, 64'hDEADBEEF);

    // load it back
    push(0, EV_R, 18'h00100, 64'h0);
    push(0, EV_R, 18'h00101, 64'h0);
    push(0, EV_D, 18'h0, 64'hDEADBEEF);
    do_req(0, 0, 1, 32'h0000_0100, 64'h0);

    // both requests: write wins, rdata untouched
    push(0, EV_W, 18'h00200, 64'h5678);
    push(0, EV_W, 18'h00201, 64'h1234);
    push(0, EV_D, 18'h0, 64'hDEADBEEF);
    do_req(0, 1, 1, 32'h0000_0200, 64'h12345678);

    // address wrap on store, then on load
    push(0, EV_W, 18'h3FFFF, 64'hF00D);
    push(0, EV_W, 18'h00000, 64'hCAFE);
    push(0, EV_D, 18'h0, 64'hDEADBEEF);
    do_req(0, 1, 0, 32'h0003_FFFF, 64'hCAFEF00D);
    push(0, EV_R, 18'h3FFFF, 64'h0);
    push(0, EV_R, 18'h00000, 64'h0);
    push(0, EV_D, 18'h0, 64'hCAFEF00D);
    do_req(0, 0, 1, 32'h0003_FFFF, 64'h0);

    // reset during the second beat of a load
    push(0, EV_R, 18'h00100, 64'h0);
    r_en0 = 1; addr0 = 32'h100;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_oe_n", {63'b0, oe_n0}, 64'd1);
    chk("mid_rst_we_n", {63'b0, we_n0}, 64'd1);
    chk("mid_rst_addr", {46'b0, saddr0}, 64'd0);
    chk("mid_rst_rdata", {32'b0, rdata0}, 64'd0);
    chk("mid_rst_dq", {48'b0, dq0}, {48'b0, KEEP});
    chk("mid_rst_ready_req", {63'b0, ready0}, 64'd0);
    r_en0 = 0;
    #1 chk("mid_rst_ready_idle", {63'b0, ready0}, 64'd1);
    chk("mid_rst_q_empty", 64'(q0.size()), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    push(0, EV_R, 18'h00100, 64'h0);
    push(0, EV_R, 18'h00101, 64'h0);
    push(0, EV_D, 18'h0, 64'hDEADBEEF);
    do_req(0, 0, 1, 32'h0000_0100, 64'h0);

    // 64-bit load with 2 wait states: 12 busy cycles, address steps every 3
    for (int i = 0; i < 12; i++) push(1, EV_R, 18'h10 + 18'(i / 3), 64'h0);
    push(1, EV_D, 18'h0, 64'h4444_3333_2222_1111);
    do_req(1, 0, 1, 32'h0000_0010, 64'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("d0_q_drained", 64'(q0.size()), 64'd0);
    chk("d1_q_drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_ctrl_multibeat.md
# sram_ctrl_multibeat

Parametrised SRAM controller between the MEM stage and an external asynchronous SRAM with a narrow data bus. It splits one DATA_W-bit load or store into DATA_W/SRAM_DW consecutive SRAM beats. Each beat is stretched by a configurable number of wait states. It holds `ready` low to stall the pipeline until the access completes. Successor of the fixed 32/16-bit controller: it adds generic widths, wait states, a registered read-data path and an explicit output-enable.

## Interface
Parameters:
- DATA_W, 32, CPU word width; must be an integer multiple of SRAM_DW.
- SRAM_DW, 16, SRAM data bus width.
- ADDR_W, 18, SRAM address width.
- WAIT_CYC, 0, extra hold cycles per beat; legal range 0..15.
- Derived: BEATS = DATA_W/SRAM_DW (≥1); BEAT_LEN = 1+WAIT_CYC; N = BEATS*BEAT_LEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_w_en  in  1  store request; held by MEM stage while `ready`=0.
- mem_r_en  in  1  load request; held by MEM stage while `ready`=0.
- addr_in  in  32  SRAM word address of the first beat; only [ADDR_W-1:0] used.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load result, registered.
- ready  out  1  0 = stall pipeline.
- sram_dq  inout  SRAM_DW  SRAM data bus.
- sram_addr  out  ADDR_W  SRAM address.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

## Operation
States:
- IDLE:
  - If mem_w_en, latch addr_in[ADDR_W-1:0], wdata and op=WRITE, then go to BUSY.
  - Else if mem_r_en, latch addr_in and op=READ, then go to BUSY.
  - Write wins when both requests are high.
  - With no request, stay in IDLE.
- BUSY:
  - beat counter b (0..BEATS-1) and wait counter w (0..WAIT_CYC) advance each cycle.
  - When w=WAIT_CYC, w wraps to 0 and b increments.
  - Leave to DONE when b=BEATS-1 and w=WAIT_CYC.
- DONE: unconditionally return to IDLE. Requests are ignored in DONE, even if still high.

Outputs are decoded only from the state, counters and latched registers, never from live inputs, except `ready`.
- `ready`:
  - IDLE: ready = ~(mem_w_en | mem_r_en), combinational.
  - BUSY: 0.
  - DONE: 1.
- BUSY WRITE:
  - sram_addr = latched_addr + b, modulo 2^ADDR_W.
  - sram_dq drives wdata slice b (slice 0 = least significant bits).
  - sram_we_n=0 and sram_oe_n=1 for every cycle of the beat.
- BUSY READ:
  - sram_addr = latched_addr + b.
  - sram_dq = Z.
  - sram_we_n=1 and sram_oe_n=0.
  - On the rising edge ending the beat (w=WAIT_CYC), sram_dq is captured into rdata slice b.
- IDLE / DONE: sram_addr=0, sram_dq=Z, sram_we_n=1, sram_oe_n=1.
- rdata:
  - Updated only by read beats.
  - Writes never modify it.
  - It holds its value until the next load overwrites it.
- Address arithmetic is ADDR_W-bit unsigned with wrap-around; no carry out.

## Timing
- The edge sampling a request in IDLE is E0.
- BUSY occupies cycles 1..N after E0; DONE occupies cycle N+1; IDLE resumes at cycle N+2.
- A pipeline stage waiting on `ready` advances at the edge ending DONE.
- Read latency: rdata holds the complete word from the start of DONE (cycle N+1).
- Back-to-back requests: a new request is first accepted at the edge ending cycle N+2 (IDLE). There is no same-cycle DONE→BUSY shortcut.
- Reset values:
  - state=IDLE, b=w=0, rdata=0.
  - sram_addr=0, sram_we_n=1, sram_oe_n=1, sram_dq=Z.
  - ready = ~(mem_w_en|mem_r_en).
- Reset mid-access takes effect immediately and asynchronously:
  - the bus is released;
  - we_n and oe_n are deasserted;
  - any partially captured rdata is cleared to 0.
- Requests dropped while in BUSY are ignored; the access still completes.

## Test plan
- Single store: defaults, store 0xDEADBEEF to 0x00100.
  - Cycle 1: we_n=0, addr=0x00100, dq=0xBEEF.
  - Cycle 2: addr=0x00101, dq=0xDEAD.
  - Cycle 3: ready=1, dq=Z.
- Load back the same word, with an SRAM model holding it.
  - Cycles 1–2: oe_n=0.
  - Cycle 3: rdata=0xDEADBEEF, ready=1. The earlier store left rdata unchanged.
- Simultaneous mem_w_en=mem_r_en=1 → write sequence only; rdata unchanged.
- Wrap-around: store to 0x3FFFF → beat addresses 0x3FFFF, then 0x00000.
- Wait states and wide word: WAIT_CYC=2, DATA_W=64.
  - Load takes 12 BUSY cycles; addr steps every 3 cycles over 4 beats.
  - ready=1 at cycle 13 with the full 64-bit word.
- Reset mid-read: assert rst in cycle 2 of a load.
  - Same cycle: oe_n=1, dq=Z, rdata=0.
  - After release, a new load completes normally.
